// File: rtl/audio_feed_pkg.sv
// Shared types and default sizing for the audio_feed sample reader.
//   state_t           : reader control states
//   DEF_*             : default widths/depths used by the interface and top
package audio_feed_pkg;

  localparam int unsigned DEF_ADDR_W       = 17;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_NUM_WORDS    = 80000;
  localparam int unsigned DEF_READ_LATENCY = 1;
  localparam int unsigned DEF_FIFO_DEPTH   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FLUSH = 3'd4
  } state_t;

endpackage : audio_feed_pkg

// File: rtl/audio_feed_sample_reader_if.sv
// Bus bundle for the sample reader: Avalon-MM read port toward the sample
// RAM plus the Avalon-ST sample stream toward the codec/DSP path.
//   master : the reader (drives mem_* requests and src_data/src_valid)
//   slave  : RAM + stream sink (drives mem_readdata and src_ready)
interface audio_feed_sample_reader_if
  import audio_feed_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output src_data, src_valid,
    input  src_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  src_data, src_valid,
    output src_ready
  );

endinterface : audio_feed_sample_reader_if

// File: rtl/audio_feed_sample_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry.
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write one entry
//   pop        : discard head entry (caller only pops when not empty)
//   clear      : drop all contents
//   rdata      : head entry, count/full/empty : occupancy
module audio_feed_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  // Pointer/occupancy bookkeeping; DEPTH is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule : audio_feed_sample_fifo

// File: rtl/audio_feed_sample_reader.sv
// Avalon-MM read master that streams a latched RAM word range out as an
// Avalon-ST sample stream, one-shot or looped. Reads are credit-limited so
// that every outstanding request already owns a FIFO slot.
//   clk, reset            : clock, synchronous active-high reset
//   start/stop            : pulses to begin/abort playback
//   loop_en               : sampled at start; wrap end_addr -> start_addr
//   start_addr/end_addr   : inclusive word range
//   bus (master)          : mem_* read port and src_* stream
//   busy/done/range_err   : status (done and range_err are 1-cycle pulses)
// READ_LATENCY must be >= 1; FIFO_DEPTH must be a power of two >= 2.
module audio_feed_sample_reader
  import audio_feed_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic [ADDR_W-1:0]          end_addr,
  audio_feed_sample_reader_if.master bus,
  output logic                       busy,
  output logic                       done,
  output logic                       range_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, end_q;
  logic                loop_q;
  logic                load_d;
  logic                cs_q, cs_d;
  logic                range_err_d;
  logic [READ_LATENCY-1:0] pipe_q;
  logic [READ_LATENCY:0]   pipe_shift;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_count, count_d;
  logic                fifo_full, fifo_empty, fifo_clear;
  logic [DATA_W-1:0]   fifo_head;
  logic                ret, push, pop, src_valid_c, range_ok;

  // Tag pipe: a request's tag leaves the pipe in the cycle its data is valid.
  assign pipe_shift = {pipe_q, cs_q};
  assign ret        = pipe_q[READ_LATENCY-1];

  // Data returning during FLUSH belongs to an aborted playback.
  assign push        = ret && (state_q != FLUSH);
  assign src_valid_c = !fifo_empty && (state_q != FLUSH);
  assign pop         = src_valid_c && bus.src_ready;
  assign fifo_clear  = (state_q == FLUSH) && (inflight_q == '0);

  assign range_ok = (start_addr <= end_addr) && (32'(end_addr) < NUM_WORDS);

  // Next-cycle occupancy, used to decide the registered request ahead of time.
  assign count_d    = fifo_clear ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign inflight_d = inflight_q + CNT_W'(cs_q) - CNT_W'(ret);

  // Next-state, address and request decision.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    load_d      = 1'b0;
    range_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_ok) begin
            state_d = RUN;
            addr_d  = start_addr;
            load_d  = 1'b1;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = FLUSH;
        end else if (cs_q) begin
          if (addr_q == end_q) begin
            if (loop_q) addr_d  = start_q;
            else        state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (stop)                                      state_d = FLUSH;
        else if ((inflight_q == '0) && fifo_empty)     state_d = DONE;
      end
      DONE: state_d = IDLE;
      FLUSH: begin
        if (inflight_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Issue next cycle only if every outstanding word still has a FIFO slot.
    cs_d = (state_d == RUN) &&
           ((SUM_W'(count_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH));
  end

  // State, request and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      pipe_q     <= '0;
      inflight_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      pipe_q     <= pipe_shift[READ_LATENCY-1:0];
      inflight_q <= inflight_d;
      busy       <= (state_d != IDLE);
      done       <= (state_d == DONE);
      range_err  <= range_err_d;
    end
  end

  // Playback range captured at an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
      end_q   <= '0;
      loop_q  <= 1'b0;
    end else if (load_d) begin
      start_q <= start_addr;
      end_q   <= end_addr;
      loop_q  <= loop_en;
    end
  end

  audio_feed_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (fifo_clear),
    .wdata (bus.mem_readdata),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.src_data       = fifo_head;
  assign bus.src_valid      = src_valid_c;

  // Credits make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule : audio_feed_sample_reader
